// File: rtl/timer_regfile_mc.sv
// System timer register bank: 64-bit prescaled counter with debug halt and NUM_CH
// compare channels, each with a sticky W1C interrupt status bit.
module timer_regfile_mc #(
    parameter int          NUM_CH  = 4,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       addr,
    input  logic [31:0]       wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              dbg_mode,
    output logic [31:0]       rd_data,
    output logic              err,
    output logic              interrupt,
    output logic [NUM_CH-1:0] irq_ch,
    output logic [63:0]       counter
);

    logic                         timer_en_q, timer_en_d;
    logic                         div_en_q, div_en_d;
    logic [3:0]                   div_val_q, div_val_d;
    logic [NUM_CH-1:0]            tier_q, tier_d;
    logic [NUM_CH-1:0]            tisr_q, tisr_d;
    logic                         halt_req_q, halt_req_d;
    logic [63:0]                  counter_q, counter_d;
    logic [7:0]                   psc_q, psc_d;
    logic [NUM_CH-1:0][63:0]      cmp_q, cmp_d;

    logic [9:0] word;
    logic [3:0] ch_idx;
    logic       sel_tcr, sel_tdr0, sel_tdr1, sel_tier, sel_tisr, sel_thcsr, sel_cmp, mapped;
    logic       halted, active, tick;
    logic [8:0] psc_lim;
    logic       unused_addr;

    assign word        = addr[11:2];
    assign unused_addr = ^addr[1:0];
    assign ch_idx      = word[4:1] - 4'd4;

    assign sel_tcr   = (word == 10'd0);
    assign sel_tdr0  = (word == 10'd1);
    assign sel_tdr1  = (word == 10'd2);
    assign sel_tier  = (word == 10'd3);
    assign sel_tisr  = (word == 10'd4);
    assign sel_thcsr = (word == 10'd5);
    assign sel_cmp   = (word >= 10'd8) && (word < 10'(8 + 2 * NUM_CH));
    assign mapped    = sel_tcr | sel_tdr0 | sel_tdr1 | sel_tier | sel_tisr | sel_thcsr | sel_cmp;

    assign err = (rd_en | wr_en) & ~mapped;

    assign halted  = halt_req_q & dbg_mode;
    assign active  = timer_en_q & ~halted;
    assign psc_lim = (9'd1 << div_val_q) - 9'd1;
    assign tick    = ~div_en_q | (psc_q == psc_lim[7:0]);

    always_comb begin
        rd_data = 32'd0;
        if (rd_en) begin
            if (sel_tcr)   rd_data = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
            if (sel_tdr0)  rd_data = counter_q[31:0];
            if (sel_tdr1)  rd_data = counter_q[63:32];
            if (sel_tier)  rd_data = 32'(tier_q);
            if (sel_tisr)  rd_data = 32'(tisr_q);
            if (sel_thcsr) rd_data = {30'd0, halted, halt_req_q};
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel_cmp && ch_idx == 4'(c))
                    rd_data = word[0] ? cmp_q[c][63:32] : cmp_q[c][31:0];
            end
        end
    end

    always_comb begin
        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        div_val_d  = div_val_q;
        tier_d     = tier_q;
        tisr_d     = tisr_q;
        halt_req_d = halt_req_q;
        cmp_d      = cmp_q;
        counter_d  = counter_q;
        psc_d      = psc_q;

        // Prescaler sits at 0 while disabled so the first tick lands 2^k cycles after enable.
        if (!timer_en_q)
            psc_d = 8'd0;
        else if (active && div_en_q)
            psc_d = tick ? 8'd0 : psc_q + 8'd1;

        if (active && tick)
            counter_d = counter_q + 64'd1;

        if (wr_en) begin
            if (sel_tcr) begin
                timer_en_d = wr_data[0];
                if (!timer_en_q) begin
                    div_en_d = wr_data[1];
                    if (wr_data[11:8] <= 4'd8) div_val_d = wr_data[11:8];
                end
            end
            if (sel_tdr0) begin
                counter_d = {counter_q[63:32], wr_data};
                psc_d     = 8'd0;
            end
            if (sel_tdr1) begin
                counter_d = {wr_data, counter_q[31:0]};
                psc_d     = 8'd0;
            end
            if (sel_tier)  tier_d     = wr_data[NUM_CH-1:0];
            if (sel_tisr)  tisr_d     = tisr_q & ~wr_data[NUM_CH-1:0];
            if (sel_thcsr) halt_req_d = wr_data[0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel_cmp && ch_idx == 4'(c)) begin
                    if (word[0]) cmp_d[c][63:32] = wr_data;
                    else         cmp_d[c][31:0]  = wr_data;
                end
            end
        end

        // Match set is applied after the W1C clear so a simultaneous match wins.
        for (int c = 0; c < NUM_CH; c++) begin
            if (counter_q == cmp_q[c]) tisr_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= 4'd1;
            tier_q     <= '0;
            tisr_q     <= '0;
            halt_req_q <= 1'b0;
            counter_q  <= 64'd0;
            psc_q      <= 8'd0;
            cmp_q      <= {NUM_CH{CMP_RST}};
        end else begin
            timer_en_q <= timer_en_d;
            div_en_q   <= div_en_d;
            div_val_q  <= div_val_d;
            tier_q     <= tier_d;
            tisr_q     <= tisr_d;
            halt_req_q <= halt_req_d;
            counter_q  <= counter_d;
            psc_q      <= psc_d;
            cmp_q      <= cmp_d;
        end
    end

    assign irq_ch    = tisr_q & tier_q;
    assign interrupt = |irq_ch;
    assign counter   = counter_q;

endmodule

// File: tb/tb_timer_regfile_mc.sv
// Scenario-driven bench for timer_regfile_mc; expected values are queued as
// stimulus is applied and popped when the DUT response is sampled.
module tb_timer_regfile_mc;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [11:0]       addr = '0;
    logic [31:0]       wr_data = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              dbg_mode = 1'b0;
    logic [31:0]       rd_data;
    logic              err;
    logic              interrupt;
    logic [NUM_CH-1:0] irq_ch;
    logic [63:0]       counter;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    logic [31:0] rd_v;
    logic        err_v;

    timer_regfile_mc #(.NUM_CH(NUM_CH), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_en(rd_en), .dbg_mode(dbg_mode), .rd_data(rd_data), .err(err),
        .interrupt(interrupt), .irq_ch(irq_ch), .counter(counter)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        #1;
        d = rd_data; e = err;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        sb.push_back(64'h100); sb.push_back(64'hFFFF_FFFF); sb.push_back(64'h0);
        bus_read(12'h000, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL reset_tcr got=%h exp=%h", rd_v, exp_v); end
        bus_read(12'h020, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL reset_tcmp_lo0 got=%h exp=%h", rd_v, exp_v); end
        bus_read(12'h010, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL reset_tisr got=%h exp=%h", rd_v, exp_v); end
        checks++;
        if (interrupt !== 1'b0 || irq_ch !== 4'h0 || counter !== 64'd0) begin
            errors++; $display("FAIL reset_outputs irq=%b irq_ch=%h cnt=%h exp 0", interrupt, irq_ch, counter);
        end
    endtask

    task automatic test_prescaler;
        bus_write(12'h000, 32'h0000_0202);
        bus_write(12'h000, 32'h0000_0902);
        sb.push_back(64'h202);
        bus_read(12'h000, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL tcr_div9_ignored got=%h exp=%h", rd_v, exp_v); end
        bus_write(12'h000, 32'h0000_0203);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            sb.push_back(64'(i / 4));
            exp_v = sb.pop_front(); checks++;
            if (counter !== exp_v) begin errors++; $display("FAIL prescale_cnt[%0d] got=%h exp=%h", i, counter, exp_v); end
        end
        bus_write(12'h000, 32'h0000_0202);
    endtask

    task automatic test_halt;
        bus_write(12'h000, 32'h0000_0000);
        bus_write(12'h004, 32'h0);
        bus_write(12'h008, 32'h0);
        bus_write(12'h014, 32'h1);
        dbg_mode = 1'b1;
        sb.push_back(64'h3);
        bus_read(12'h014, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL thcsr_halted got=%h exp=%h", rd_v, exp_v); end
        bus_write(12'h000, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            sb.push_back(64'd0);
            exp_v = sb.pop_front(); checks++;
            if (counter !== exp_v) begin errors++; $display("FAIL halt_frozen[%0d] got=%h exp=%h", i, counter, exp_v); end
        end
        dbg_mode = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            sb.push_back(64'(i));
            exp_v = sb.pop_front(); checks++;
            if (counter !== exp_v) begin errors++; $display("FAIL halt_resume[%0d] got=%h exp=%h", i, counter, exp_v); end
        end
        dbg_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sb.push_back(64'd5);
            exp_v = sb.pop_front(); checks++;
            if (counter !== exp_v) begin errors++; $display("FAIL halt_refreeze[%0d] got=%h exp=%h", i, counter, exp_v); end
        end
        bus_write(12'h014, 32'h0);
        dbg_mode = 1'b0;
        bus_write(12'h000, 32'h0000_0000);
    endtask

    task automatic test_irq;
        bus_write(12'h004, 32'h0);
        bus_write(12'h008, 32'h0);
        bus_write(12'h030, 32'h10);
        bus_write(12'h034, 32'h0);
        bus_write(12'h010, 32'hF);
        bus_write(12'h00C, 32'h4);
        bus_write(12'h000, 32'h1);
        for (int i = 0; i <= 17; i++) begin
            if (i > 0) @(negedge clk);
            sb.push_back({56'(i), 4'h0, (i >= 17) ? 4'h4 : 4'h0});
            exp_v = sb.pop_front(); checks++;
            if (counter !== 64'(exp_v[63:8]) || irq_ch !== exp_v[3:0] || interrupt !== (|exp_v[3:0])) begin
                errors++;
                $display("FAIL irq_seq[%0d] cnt=%h irq_ch=%h int=%b exp cnt=%h irq_ch=%h", i, counter, irq_ch, interrupt, exp_v[63:8], exp_v[3:0]);
            end
        end
        bus_write(12'h000, 32'h0);
        bus_write(12'h010, 32'h4);
        sb.push_back(64'h0);
        bus_read(12'h010, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v || irq_ch !== 4'h0) begin
            errors++; $display("FAIL tisr_w1c got=%h irq_ch=%h exp=%h", rd_v, irq_ch, exp_v);
        end
        bus_write(12'h004, 32'h10);
        bus_write(12'h010, 32'h4);
        sb.push_back(64'h4);
        bus_read(12'h010, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL tisr_set_wins got=%h exp=%h", rd_v, exp_v); end
        bus_write(12'h004, 32'h20);
        bus_write(12'h010, 32'hF);
    endtask

    task automatic test_wrap_load;
        bus_write(12'h000, 32'h0);
        bus_write(12'h008, 32'hFFFF_FFFF);
        bus_write(12'h004, 32'hFFFF_FFFE);
        sb.push_back(64'hFFFF_FFFE);
        bus_read(12'h004, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL tdr0_load got=%h exp=%h", rd_v, exp_v); end
        bus_write(12'h000, 32'h1);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFE); sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        sb.push_back(64'h0); sb.push_back(64'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            exp_v = sb.pop_front(); checks++;
            if (counter !== exp_v) begin errors++; $display("FAIL wrap_cnt[%0d] got=%h exp=%h", i, counter, exp_v); end
        end
        bus_write(12'h004, 32'h100);
        sb.push_back(64'h100); sb.push_back(64'h101);
        exp_v = sb.pop_front(); checks++;
        if (counter !== exp_v) begin errors++; $display("FAIL tdr_beats_inc got=%h exp=%h", counter, exp_v); end
        @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (counter !== exp_v) begin errors++; $display("FAIL after_load_inc got=%h exp=%h", counter, exp_v); end
        bus_write(12'h000, 32'h803);
        sb.push_back(64'h001);
        bus_read(12'h000, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL tcr_locked_when_en got=%h exp=%h", rd_v, exp_v); end
        bus_write(12'h000, 32'h0);
    endtask

    task automatic test_unmapped;
        bus_read(12'h018, rd_v, err_v);
        checks++;
        if (rd_v !== 32'h0 || err_v !== 1'b1) begin
            errors++; $display("FAIL unmapped_read rd=%h err=%b exp rd=0 err=1", rd_v, err_v);
        end
        bus_read(12'h000, rd_v, err_v);
        checks++;
        if (err_v !== 1'b0) begin errors++; $display("FAIL mapped_no_err err=%b exp=0", err_v); end
        @(negedge clk);
        addr = 12'h020; rd_en = 1'b0; #1;
        checks++;
        if (rd_data !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL rd_en_low rd=%h err=%b exp 0/0", rd_data, err);
        end
        @(negedge clk);
        addr = 12'h020 + 12'(8 * NUM_CH); wr_data = 32'hFFFF_FFFF; wr_en = 1'b1; #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL unmapped_write_err err=%b exp=1", err); end
        @(negedge clk);
        wr_en = 1'b0;
        sb.push_back(64'h0); sb.push_back(64'h4); sb.push_back(64'hFFFF_FFFF); sb.push_back(64'h0);
        bus_read(12'h000, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL unmapped_wr_tcr got=%h exp=%h", rd_v, exp_v); end
        bus_read(12'h00C, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL unmapped_wr_tier got=%h exp=%h", rd_v, exp_v); end
        bus_read(12'h038, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL unmapped_wr_cmp3lo got=%h exp=%h", rd_v, exp_v); end
        bus_read(12'h014, rd_v, err_v);
        exp_v = sb.pop_front(); checks++;
        if (64'(rd_v) !== exp_v) begin errors++; $display("FAIL unmapped_wr_thcsr got=%h exp=%h", rd_v, exp_v); end
    endtask

    task automatic test_async_reset;
        bus_write(12'h008, 32'h0);
        bus_write(12'h004, 32'h10);
        @(negedge clk);
        checks++;
        if (interrupt !== 1'b1 || irq_ch !== 4'h4) begin
            errors++; $display("FAIL pre_reset_irq int=%b irq_ch=%h exp 1/4", interrupt, irq_ch);
        end
        bus_write(12'h000, 32'h1);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        addr = 12'h000; rd_en = 1'b1; #1;
        checks++;
        if (counter !== 64'd0 || interrupt !== 1'b0 || irq_ch !== 4'h0 || rd_data !== 32'h100) begin
            errors++;
            $display("FAIL async_reset cnt=%h int=%b irq_ch=%h tcr=%h exp 0/0/0/100", counter, interrupt, irq_ch, rd_data);
        end
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (counter !== 64'd0) begin errors++; $display("FAIL post_reset_idle cnt=%h exp=0", counter); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_prescaler();
        test_halt();
        test_irq();
        test_wrap_load();
        test_unmapped();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_regfile_mc.md
# timer_regfile_mc

Multi-channel register bank and 64-bit counter core for the system timer, the parametrised successor of the single-compare timer register block. It decodes a 32-bit register bus and owns the free-running 64-bit counter with a power-of-two prescaler and debug halt. It provides NUM_CH independent 64-bit compare channels, each with a sticky, write-1-to-clear interrupt status bit. The block sits between the bus slave interface and the interrupt controller.

## Interface
- NUM_CH, 4, number of compare channels, legal range 1..8.
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every compare register.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- addr  in  12  byte address; bits [1:0] ignored.
- wr_data  in  32  write data.
- wr_en  in  1  write strobe, one access per cycle.
- rd_en  in  1  read strobe.
- dbg_mode  in  1  CPU debug state.
- rd_data  out  32  read data, combinational.
- err  out  1  access to an unmapped address, combinational.
- interrupt  out  1  OR of (TISR & TIER).
- irq_ch  out  NUM_CH  per-channel TISR & TIER.
- counter  out  64  current counter value.

## Operation
- Map:
  - 0x000 TCR: [0] timer_en, [1] div_en, [11:8] div_val. Reset 0x0000_0100.
  - 0x004 TDR0: counter[31:0].
  - 0x008 TDR1: counter[63:32].
  - 0x00C TIER: [NUM_CH-1:0] enables. Reset 0.
  - 0x010 TISR: [NUM_CH-1:0] status, W1C. Reset 0.
  - 0x014 THCSR: [0] halt_req RW; [1] halt_ack RO = halt_req & dbg_mode.
  - 0x020+8*c: TCMP_LO[c]; 0x024+8*c: TCMP_HI[c], for c < NUM_CH.
- Unlisted bits read 0 and ignore writes. Reads with rd_en=0 return 0.
- An unmapped address reads 0, ignores writes and raises err while rd_en or wr_en is high.
- TCR write legality:
  - div_val > 8: the div_val field keeps its old value; other fields still update.
  - While timer_en=1, writes to div_en and div_val are ignored. timer_en itself is always writable.
- Counting:
  - Active when timer_en=1 and not halted, where halted = halt_req & dbg_mode.
  - div_en=0: counter increments every active cycle.
  - div_en=1: a prescaler counter runs; counter increments when it reaches 2^div_val-1, then the prescaler returns to 0.
  - div_val=0 with div_en=1 increments every cycle.
  - Halt freezes both counter and prescaler.
  - timer_en 1->0 clears the prescaler; the counter holds its value.
  - Wrap: 0xFFFF_FFFF_FFFF_FFFF -> 0, with no flag.
- TDR writes load the written half of the counter. The other half is unchanged and there is no carry.
  - A TDR write beats an increment in the same cycle.
  - A TDR write clears the prescaler.
- Compare: TISR[c] is set in every cycle where the registered counter == {TCMP_HI[c], TCMP_LO[c]}, independent of TIER and of timer_en.
- TISR clear: writing 1 clears the bit; writing 0 has no effect. A set and a clear in the same cycle: set wins.
- TCMP write: partial updates are visible immediately. Software disables TIER to avoid spurious matches.

## Timing
- Register writes take effect at the rising edge where wr_en=1, and are visible on rd_data in the next cycle.
- rd_data and err have zero-cycle latency from addr and rd_en.
- Match to TISR: the counter equals the compare value in cycle N; TISR[c]=1 from cycle N+1.
- interrupt and irq_ch follow TISR and TIER combinationally, so they assert at N+1.
- Prescaled rate: with div_val=k, the counter advances once every 2^k active cycles. The first increment lands 2^k cycles after timer_en goes to 1.
- Reset (asynchronous, mid-operation included): all registers return to reset values immediately.
  - counter=0, interrupt=0, irq_ch=0, err depends only on inputs.
  - The prescaler returns to 0.

## Test plan
- Reset defaults: after reset, read TCR -> 0x0000_0100; read TCMP_LO[0] -> 0xFFFF_FFFF; read TISR -> 0; interrupt=0.
- Prescaler: div_en=1, div_val=2, timer_en=1 -> counter advances every 4 cycles. Writing div_val=9 while the timer is disabled -> TCR[11:8] reads back 2.
- Halt: halt_req=1 with dbg_mode=1 -> counter frozen and THCSR reads 0x3. Deasserting dbg_mode -> counting resumes from the frozen value.
- Multi-channel interrupt (NUM_CH=4): TCMP[2]=0x10, TIER=0x4, counting from 0 -> TISR=0x4 and irq_ch=0x4 one cycle after counter=0x10. Writing TISR=0x4 clears it. A clear in the same cycle as a match leaves the bit set.
- Wrap and load: write TDR1=0xFFFF_FFFF and TDR0=0xFFFF_FFFE, enable -> counter reads ...FFFF, then 0x0. A TDR0 write during counting wins over the increment.
- Unmapped access: rd_en at 0x018 -> rd_data=0 and err=1. Writing 0x020+8*NUM_CH -> err=1 and no register changes.
